// File: rtl/booth_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Combinational definitions only; no latency or backpressure of its own.
package booth_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    localparam int DIV_WIDTH     = 16;
    localparam int DIV_LAT_FULL  = DIV_WIDTH + 2;
    localparam int DIV_LAT_SHORT = 2;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational (zero latency); no handshake.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
    assign shifted = {rem_i, dvd_bit_i};
    assign trial   = shifted - {1'b0, dvs_i};
    assign q_bit_o = ~trial[WIDTH];
    assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/booth_seq_divider.sv
// Radix-2 restoring divider, signed/unsigned; optional BOOTH_DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
// Latency WIDTH+2 (2 for zero divisor or early-out); result held while out_ready low, in_ready only when idle.
module booth_seq_divider
    import booth_div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    assign mag_dvd = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    assign mag_dvs = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        orig_d    = orig_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    orig_d  = dividend;
                    dvs_d   = divisor;
                    sgn_d   = signed_op;
                    state_d = PREP;
                end
            end
            PREP: begin
                dvd_d     = mag_dvd;
                dvs_d     = mag_dvs;
                quo_neg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                rem_neg_d = sgn_q & dvd_q[WIDTH-1];
                if (dvs_q == '0) begin
                    dz_d    = 1'b1;
                    state_d = FIX;
                end else begin
                    dz_d    = 1'b0;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = CALC;
`ifdef BOOTH_DIV_EARLY_OUT_EN
                    // Quotient 0, remainder |dividend|: FIX re-applies the dividend sign.
                    if (mag_dvd < mag_dvs) begin
                        rem_d   = mag_dvd;
                        dvd_d   = '0;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quo_out_d = '1;
                    rem_out_d = orig_q;
                    dbz_d     = 1'b1;
                end else begin
                    quo_out_d = quo_neg_q ? -dvd_q : dvd_q;
                    rem_out_d = rem_neg_q ? -rem_q : rem_q;
                    dbz_d     = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            orig_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            orig_q    <= orig_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Scoreboarded bench for booth_seq_divider: directed cases, back-pressure, mid-operation reset, random operands.
// Expected results come from plain integer division in the bench.
module tb_booth_seq_divider;

    localparam int W = 16;
`ifdef BOOTH_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int LAT_FULL = W + 2;
    localparam int LAT_SHORT = 2;
    localparam int N_RANDOM = 1500;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    booth_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_op   (signed_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bp_mode = 2;   // 0 random, 1 hold low, 2 hold high
    exp_t sb[$];
    exp_t cur;
    bit   holding = 1'b0;
    bit   ir_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        exp_t   e;
        longint sa, sbv, ma, mb;
        sa  = sg ? longint'($signed(a)) : longint'(a);
        sbv = sg ? longint'($signed(b)) : longint'(b);
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sbv < 0) ? -sbv : sbv;
        e.acc = 0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = LAT_SHORT;
        end else begin
            e.q   = W'(sa / sbv);
            e.r   = W'(sa % sbv);
            e.dz  = 1'b0;
            e.lat = (EARLY && (ma < mb)) ? LAT_SHORT : LAT_FULL;
        end
        return e;
    endfunction

    // Scoreboard monitor: first out_valid cycle pops and checks values + latency, later cycles check hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            holding    = 1'b0;
            ir_pending = 1'b0;
        end else begin
            if (ir_pending) begin
                chk("in_ready_after_pop", {31'd0, in_ready}, 32'd1);
                ir_pending = 1'b0;
            end
            if (out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        holding = 1'b1;
                        chk("quotient", {16'd0, quotient}, {16'd0, cur.q});
                        chk("remainder", {16'd0, remainder}, {16'd0, cur.r});
                        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, cur.dz});
                        chk("latency", cyc - cur.acc, cur.lat);
                    end
                end else begin
                    chk("hold_quotient", {16'd0, quotient}, {16'd0, cur.q});
                    chk("hold_remainder", {16'd0, remainder}, {16'd0, cur.r});
                    chk("hold_dbz", {31'd0, div_by_zero}, {31'd0, cur.dz});
                end
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (out_ready && holding) begin
                    holding    = 1'b0;
                    ir_pending = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input exp_t e);
        int t;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = sg;
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            dividend  = W'($urandom);
            divisor   = W'($urandom);
            signed_op = 1'($urandom);
        end
    endtask

    task automatic issue_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.acc = 0;
        issue(a, b, sg, e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || holding || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return W'(0);
            1:       return W'(1);
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            4:       return W'($urandom_range(0, 15));
            5:       return W'($urandom_range(0, 255));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic         sg;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        issue_exp(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0, LAT_FULL);
        issue_exp(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, LAT_FULL);
        issue_exp(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, LAT_FULL);
        issue_exp(16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, LAT_SHORT);
        issue_exp(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, LAT_FULL);
        issue_exp(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, LAT_FULL);
        issue_exp(16'd3, 16'd5, 1'b0, 16'd0, 16'd3, 1'b0, EARLY ? LAT_SHORT : LAT_FULL);
        issue_exp(16'hFFFD, 16'h0005, 1'b1, 16'd0, 16'hFFFD, 1'b0, EARLY ? LAT_SHORT : LAT_FULL);
        drain();

        // Back-pressure: result must hold for 10 cycles with out_ready low.
        bp_mode = 1;
        issue_exp(16'd50000, 16'd123, 1'b0, 16'd406, 16'd62, 1'b0, LAT_FULL);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        end
        repeat (10) @(negedge clk);
        chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        bp_mode = 2;
        drain();

        // Mid-CALC reset: abort, no result.
        issue_exp(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0, LAT_FULL);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_quotient", {16'd0, quotient}, 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        #1;
        rst_n = 1'b1;
        issue_exp(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, LAT_FULL);
        drain();

        bp_mode = 0;
        for (int i = 0; i < N_RANDOM; i++) begin
            a  = pick();
            b  = pick();
            sg = 1'($urandom);
            issue(a, b, sg, model(a, b, sg));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bp_mode = 2;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
